// File: rtl/byte_lane_sp_ram_pkg.sv
// Shared constants for byte_lane_sp_ram: FSM encoding, read-during-write modes, lane width.
package byte_lane_sp_ram_pkg;

  localparam int LANE_W = 8;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

endpackage

// File: rtl/byte_lane_sp_ram_lane.sv
// One 8-bit byte lane: depth x 8 array with a single write enable and a registered read port.
module byte_lane_sp_ram_lane
  import byte_lane_sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int RDW_MODE   = RDW_OLD
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LANE_W-1:0]     din,
  output logic [LANE_W-1:0]     dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [LANE_W-1:0] mem [DEPTH];
  logic [LANE_W-1:0] rd_q;

  // Array and read register carry no reset so the lane maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end
      if (we && (RDW_MODE == RDW_NEW)) begin
        rd_q <= din;
      end else begin
        rd_q <= mem[addr];
      end
    end
  end

  assign dout = rd_q;

endmodule

// File: rtl/byte_lane_sp_ram.sv
// Byte-lane single-port RAM with req/ready handshake, registered read-valid strobe and
// optional post-reset zero-fill sweep (enabled by defining BYTE_LANE_SP_RAM_ZERO_INIT_EN).
module byte_lane_sp_ram
  import byte_lane_sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = RDW_OLD
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req,
  input  logic [DATA_WIDTH/LANE_W-1:0] we,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic                         ready,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         dout_valid,
  output logic                         init_done,
  output state_t                       dbg_state
);

  localparam int NUM_LANES = DATA_WIDTH / LANE_W;

  // Handshake: a request is taken on a rising edge where req && ready; ready is a flop
  // output with no path from req, and each taken request yields one dout_valid pulse.
  state_t state_q, state_d;
  logic   ready_q, ready_d;
  logic   init_done_q, init_done_d;
  logic   vld1_q, vld1_d;
  logic   accept;

  logic                  sweep_act;
  logic                  sweep_done;
  logic [ADDR_WIDTH-1:0] sweep_addr;

  logic                  ram_en;
  logic [NUM_LANES-1:0]  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] rd_word;

  assign accept = req && ready_q;

`ifdef BYTE_LANE_SP_RAM_ZERO_INIT_EN
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;

  // reset_n gates the sweep so nothing is written while reset is held.
  always_comb begin
    sweep_act  = (state_q == ST_INIT) && !cnt_q[ADDR_WIDTH] && reset_n;
    cnt_d      = cnt_q;
    if (sweep_act) begin
      cnt_d = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end
    sweep_done = cnt_d[ADDR_WIDTH];
    sweep_addr = cnt_q[ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign sweep_act  = 1'b0;
  assign sweep_done = 1'b1;
  assign sweep_addr = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (sweep_done) state_d = ST_IDLE;
      ST_IDLE: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
    ready_d     = (state_q == ST_IDLE);
    init_done_d = (state_q == ST_IDLE);
    vld1_d      = accept;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      vld1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      vld1_q      <= vld1_d;
    end
  end

  // Sweep and user traffic never overlap: accept needs ready, which only exists in IDLE.
  always_comb begin
    ram_en   = accept;
    ram_we   = accept ? we : '0;
    ram_addr = addr;
    ram_din  = din;
    if (sweep_act) begin
      ram_en   = 1'b1;
      ram_we   = '1;
      ram_addr = sweep_addr;
      ram_din  = '0;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    byte_lane_sp_ram_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RDW_MODE   (RDW_MODE)
    ) u_lane (
      .clk  (clk),
      .en   (ram_en),
      .we   (ram_we[k]),
      .addr (ram_addr),
      .din  (ram_din[k*LANE_W +: LANE_W]),
      .dout (rd_word[k*LANE_W +: LANE_W])
    );
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                  vld2_q;
    logic [DATA_WIDTH-1:0] oreg_q, oreg_d;

    always_comb begin
      oreg_d = vld1_q ? rd_word : oreg_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld2_q <= 1'b0;
        oreg_q <= '0;
      end else begin
        vld2_q <= vld1_q;
        oreg_q <= oreg_d;
      end
    end

    assign dout_valid = vld2_q;
    assign dout       = vld2_q ? oreg_q : '0;
  end else begin : g_noreg
    assign dout_valid = vld1_q;
    assign dout       = vld1_q ? rd_word : '0;
  end

  assign ready     = ready_q;
  assign init_done = init_done_q;
  assign dbg_state = state_q;

endmodule
